flac_subframe_sequencer: RTL and testbench

- Frame-level controller for the fixed-predictor subframe decoder (fixedDecode2).
- Walks the subframes of one FLAC frame held in sample RAM, one subframe per channel.
- For each subframe: fetches and parses the header, configures the decoder's order and start address, and runs it until the block's samples are produced.
- Owns the single RAM read port, muxing it between its own header fetches and the decoder.

---
 rtl/flac_subframe_sequencer_if.sv | 37 +++
 rtl/flac_subframe_sequencer.sv | 110 +++++++++++
 tb/tb_flac_subframe_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/flac_subframe_sequencer_if.sv
// flac_subframe_sequencer_if: frame request, RAM read port and fixed-decoder control bundle.
// The cycles signal exists only when SEQ_PERF_CNT_EN is defined.
interface flac_subframe_sequencer_if #(parameter int CH_W = 4);
  logic            start;
  logic [15:0]     frame_addr;
  logic [15:0]     block_size;
  logic [CH_W-1:0] channels;
  logic [15:0]     ram_addr;
  logic [15:0]     ram_data;
  logic            dec_rst;
  logic            dec_enable;
  logic [3:0]      dec_order;
  logic [15:0]     dec_start_addr;
  logic [15:0]     dec_read_addr;
  logic [15:0]     dec_samples_read;
  logic [CH_W-1:0] channel;
  logic            busy;
  logic            done;
  logic            error;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]     cycles;
`endif
  modport master (
    input  start, frame_addr, block_size, channels, ram_data, dec_read_addr, dec_samples_read,
    output ram_addr, dec_rst, dec_enable, dec_order, dec_start_addr, channel, busy, done, error
`ifdef SEQ_PERF_CNT_EN
    , output cycles
`endif
  );
  modport slave (
    output start, frame_addr, block_size, channels, ram_data, dec_read_addr, dec_samples_read,
    input  ram_addr, dec_rst, dec_enable, dec_order, dec_start_addr, channel, busy, done, error
`ifdef SEQ_PERF_CNT_EN
    , input cycles
`endif
  );
endinterface

// File: rtl/flac_subframe_sequencer.sv
// flac_subframe_sequencer: walks a FLAC frame's fixed-predictor subframes and drives the decoder.
// Define SEQ_PERF_CNT_EN to add the busy-cycle counter output.
module flac_subframe_sequencer #(
  parameter int CH_W           = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                       clk,
  input logic                       rst_n,
  flac_subframe_sequencer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, FETCH, PARSE, LAUNCH, RUN, NEXT, DONE, ERR} state_t;
  state_t          state;
  logic [15:0]     hdr_addr;
  logic [15:0]     blk;
  logic [CH_W-1:0] chs;
  logic [WD_W-1:0] wd;
  logic [7:0]      hdr;
  logic            hdr_ok;
  logic            bad_cfg;
  logic            unused_ok;
  assign hdr       = bus.ram_data[15:8];
  // pad=0, wasted=0, type 001ooo with ooo<=4
  assign hdr_ok    = !hdr[7] && !hdr[0] && hdr[6:4] == 3'b001 && hdr[3:1] <= 3'd4;
  assign bad_cfg   = bus.channels == '0 || bus.block_size == '0;
  assign unused_ok = ^bus.ram_data[7:0];
  assign bus.ram_addr = state == RUN ? bus.dec_read_addr : hdr_addr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state              <= IDLE;
      hdr_addr           <= '0;
      blk                <= '0;
      chs                <= '0;
      wd                 <= '0;
      bus.dec_rst        <= 1'b1;
      bus.dec_enable     <= 1'b0;
      bus.dec_order      <= '0;
      bus.dec_start_addr <= '0;
      bus.channel        <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.error          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, ERR: if (bus.start) begin
          hdr_addr       <= bus.frame_addr;
          blk            <= bus.block_size;
          chs            <= bus.channels;
          bus.channel    <= '0;
          bus.error      <= bad_cfg;
          bus.busy       <= !bad_cfg;
          bus.dec_rst    <= bad_cfg;
          bus.dec_enable <= 1'b0;
          state          <= bad_cfg ? ERR : FETCH;
        end
        FETCH: state <= PARSE;
        PARSE: begin
          state       <= hdr_ok ? LAUNCH : ERR;
          bus.dec_rst <= 1'b1;
          bus.busy    <= hdr_ok;
          bus.error   <= !hdr_ok;
          if (hdr_ok) begin
            bus.dec_order      <= {1'b0, hdr[3:1]};
            bus.dec_start_addr <= hdr_addr + 16'd1;
          end
        end
        LAUNCH: begin
          state          <= RUN;
          bus.dec_rst    <= 1'b0;
          bus.dec_enable <= 1'b1;
          wd             <= '0;
        end
        // completion is tested first so it wins over a coincident watchdog expiry
        RUN: if (bus.dec_samples_read == blk) begin
          state          <= NEXT;
          bus.dec_enable <= 1'b0;
        end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
          state          <= ERR;
          bus.dec_enable <= 1'b0;
          bus.dec_rst    <= 1'b1;
          bus.busy       <= 1'b0;
          bus.error      <= 1'b1;
        end else begin
          wd <= wd + 1'b1;
        end
        NEXT: begin
          hdr_addr <= bus.dec_read_addr + 16'd1;
          if (bus.channel + 1'b1 == chs) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            bus.channel <= bus.channel + 1'b1;
            state       <= FETCH;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.cycles <= '0;
    else if (bus.start && (state == IDLE || state == ERR)) bus.cycles <= '0;
    else if (bus.busy) bus.cycles <= bus.cycles + 32'd1;
`endif
endmodule

// File: tb/tb_flac_subframe_sequencer.sv
// tb_flac_subframe_sequencer: scoreboard bench with RAM and fixed-decoder models.
module tb_flac_subframe_sequencer;
  localparam int CH_W = 4;
  localparam int TO   = 100;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  flac_subframe_sequencer_if #(.CH_W(CH_W)) bus();
  flac_subframe_sequencer #(.CH_W(CH_W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [15:0] mem [0:63];
  logic [15:0] end_tab [0:3];
  logic [15:0] stall;
  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];
  logic prev_err = 1'b0;
  int busy_cnt, en_cnt, n;
  logic en_seen;
  assign bus.ram_data = mem[bus.ram_addr[5:0]];
  // decoder model: counts samples up to min(block, stall), read address up to this channel's end
  always_ff @(posedge clk)
    if (bus.dec_rst) begin
      bus.dec_samples_read <= '0;
      bus.dec_read_addr    <= bus.dec_start_addr;
    end else if (bus.dec_enable) begin
      if (bus.dec_samples_read < bus.block_size && bus.dec_samples_read < stall)
        bus.dec_samples_read <= bus.dec_samples_read + 16'd1;
      if (bus.dec_read_addr < end_tab[bus.channel[1:0]])
        bus.dec_read_addr <= bus.dec_read_addr + 16'd1;
    end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic sb_check(input string tag, input logic [63:0] obs);
    if (sb_q.size() == 0) check({tag, "_unexpected"}, obs, 64'h0);
    else check(tag, obs, sb_q.pop_front());
  endtask
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      if (bus.busy && bus.dec_rst)
        sb_check("launch", {8'h01, bus.channel, bus.dec_order, 16'h0, bus.ram_addr, bus.dec_start_addr});
      if (bus.done) sb_check("done", {8'h02, bus.channel, 52'h0});
      if (bus.error && !prev_err) sb_check("error", {8'h03, bus.channel, 52'h0});
      if (bus.busy) busy_cnt++;
      if (bus.dec_enable) begin
        en_cnt++;
        en_seen = 1'b1;
      end
    end
    prev_err = bus.error;
  endtask
  task automatic pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic run(input int budget, output int cnt);
    cnt = 0;
    while (!(bus.done || bus.error) && cnt < budget) begin
      tick();
      cnt++;
    end
    if (!(bus.done || bus.error)) check("frame_end_wait", 64'd0, 64'd1);
  endtask
  task automatic push_launch(input logic [3:0] ch, input logic [3:0] ord, input logic [15:0] ha);
    sb_q.push_back({8'h01, ch, ord, 16'h0, ha, ha + 16'd1});
  endtask
  task automatic push_end(input logic [7:0] kind, input logic [3:0] ch);
    sb_q.push_back({kind, ch, 52'h0});
  endtask
  task automatic frame1(input string tag);
    mem[4] = 16'h18AB;
    end_tab[0] = 16'd10;
    bus.channels = 4'd1;
    push_launch(4'd0, 4'd4, 16'd4);
    push_end(8'h02, 4'd0);
    busy_cnt = 0;
    pulse();
    run(200, n);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd22);
    check({tag, "_error"}, 64'(bus.error), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.frame_addr = 16'd4;
    bus.block_size = 16'd16;
    bus.channels = 4'd1;
    stall = 16'hFFFF;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0;
    for (int i = 0; i < 4; i++) end_tab[i] = 16'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("rst_dec_rst", 64'(bus.dec_rst), 64'd1);
    check("rst_dec_enable", 64'(bus.dec_enable), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_error", 64'(bus.error), 64'd0);
    rst_n = 1'b1;
    tick();
    // single channel, order 4
    frame1("t1");
`ifdef SEQ_PERF_CNT_EN
    check("t1_perf_cycles", 64'(bus.cycles), 64'd22);
`endif
    // two channels, orders 2 then 0, second header follows first subframe's last word
    mem[4] = 16'h1400;
    mem[10] = 16'h1000;
    end_tab[0] = 16'd9;
    end_tab[1] = 16'd14;
    bus.channels = 4'd2;
    push_launch(4'd0, 4'd2, 16'd4);
    push_launch(4'd1, 4'd0, 16'd10);
    push_end(8'h02, 4'd1);
    busy_cnt = 0;
    pulse();
    run(300, n);
    check("t2_busy_cycles", 64'(busy_cnt), 64'd43);
    check("t2_error", 64'(bus.error), 64'd0);
    tick();
    // start pulsed during RUN must be ignored
    mem[4] = 16'h18AB;
    end_tab[0] = 16'd10;
    bus.channels = 4'd1;
    push_launch(4'd0, 4'd4, 16'd4);
    push_end(8'h02, 4'd0);
    pulse();
    n = 0;
    while (!bus.dec_enable && n < 20) begin
      tick();
      n++;
    end
    check("t6_reach_run", 64'(bus.dec_enable), 64'd1);
    pulse();
    run(200, n);
    check("t6_done", 64'(bus.done), 64'd1);
    tick();
    // bad headers: order 5, then verbatim
    mem[4] = 16'h1A00;
    push_end(8'h03, 4'd0);
    en_seen = 1'b0;
    pulse();
    run(10, n);
    check("t3_ord5_latency_ok", 64'(n <= 3), 64'd1);
    check("t3_ord5_error", 64'(bus.error), 64'd1);
    check("t3_ord5_busy", 64'(bus.busy), 64'd0);
    mem[4] = 16'h0200;
    push_end(8'h03, 4'd0);
    pulse();
    run(10, n);
    check("t3_verb_latency_ok", 64'(n <= 3), 64'd1);
    check("t3_verb_error", 64'(bus.error), 64'd1);
    check("t3_no_enable", 64'(en_seen), 64'd0);
    // watchdog: decoder stalls at 7 samples
    mem[4] = 16'h1800;
    stall = 16'd7;
    push_launch(4'd0, 4'd4, 16'd4);
    push_end(8'h03, 4'd0);
    en_cnt = 0;
    pulse();
    run(400, n);
    check("t4_run_cycles", 64'(en_cnt), 64'(TO));
    check("t4_error", 64'(bus.error), 64'd1);
    check("t4_dec_rst", 64'(bus.dec_rst), 64'd1);
    check("t4_enable", 64'(bus.dec_enable), 64'd0);
    stall = 16'hFFFF;
    push_launch(4'd0, 4'd4, 16'd4);
    push_end(8'h02, 4'd0);
    pulse();
    check("t4_error_cleared", 64'(bus.error), 64'd0);
    run(200, n);
    check("t4_recover_done", 64'(bus.done), 64'd1);
    tick();
    // zero channels
    bus.channels = 4'd0;
    push_end(8'h03, 4'd0);
    pulse();
    run(10, n);
    check("t6_ch0_error", 64'(bus.error), 64'd1);
    check("t6_ch0_busy", 64'(bus.busy), 64'd0);
    bus.channels = 4'd1;
    // reset in RUN at sample 5
    push_launch(4'd0, 4'd4, 16'd4);
    pulse();
    n = 0;
    while (bus.dec_samples_read != 16'd5 && n < 50) begin
      tick();
      n++;
    end
    check("t5_reach_s5", 64'(bus.dec_samples_read), 64'd5);
    rst_n = 1'b0;
    #1;
    check("t5_ram_addr", 64'(bus.ram_addr), 64'd0);
    check("t5_start_addr", 64'(bus.dec_start_addr), 64'd0);
    check("t5_order", 64'(bus.dec_order), 64'd0);
    check("t5_channel", 64'(bus.channel), 64'd0);
    check("t5_dec_rst", 64'(bus.dec_rst), 64'd1);
    check("t5_enable", 64'(bus.dec_enable), 64'd0);
    check("t5_busy", 64'(bus.busy), 64'd0);
    check("t5_done", 64'(bus.done), 64'd0);
    check("t5_error", 64'(bus.error), 64'd0);
    sb_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t5_idle_busy", 64'(bus.busy), 64'd0);
    check("t5_idle_dec_rst", 64'(bus.dec_rst), 64'd1);
    frame1("t5_post");
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
